// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM encoding, SPARC opcodes, icc layout and
// opcode classification helpers.
package alu_seq_pkg;

  localparam int unsigned OpW = 6;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StStrobe  = 3'd2,
    StCapture = 3'd3,
    StResp    = 3'd4
  } seq_state_e;

  localparam logic [OpW-1:0] OpAdd    = 6'b000000;
  localparam logic [OpW-1:0] OpAnd    = 6'b000001;
  localparam logic [OpW-1:0] OpOr     = 6'b000010;
  localparam logic [OpW-1:0] OpXor    = 6'b000011;
  localparam logic [OpW-1:0] OpSub    = 6'b000100;
  localparam logic [OpW-1:0] OpAndn   = 6'b000101;
  localparam logic [OpW-1:0] OpOrn    = 6'b000110;
  localparam logic [OpW-1:0] OpXnor   = 6'b000111;
  localparam logic [OpW-1:0] OpAddx   = 6'b001000;
  localparam logic [OpW-1:0] OpSubx   = 6'b001100;
  localparam logic [OpW-1:0] OpAddcc  = 6'b010000;
  localparam logic [OpW-1:0] OpAndcc  = 6'b010001;
  localparam logic [OpW-1:0] OpOrcc   = 6'b010010;
  localparam logic [OpW-1:0] OpXorcc  = 6'b010011;
  localparam logic [OpW-1:0] OpSubcc  = 6'b010100;
  localparam logic [OpW-1:0] OpAndncc = 6'b010101;
  localparam logic [OpW-1:0] OpOrncc  = 6'b010110;
  localparam logic [OpW-1:0] OpXnorcc = 6'b010111;
  localparam logic [OpW-1:0] OpAddxcc = 6'b011000;
  localparam logic [OpW-1:0] OpSubxcc = 6'b011100;
  localparam logic [OpW-1:0] OpSll    = 6'b100101;
  localparam logic [OpW-1:0] OpSrl    = 6'b100110;
  localparam logic [OpW-1:0] OpSra    = 6'b100111;

  localparam int unsigned IccN = 3;
  localparam int unsigned IccZ = 2;
  localparam int unsigned IccV = 1;
  localparam int unsigned IccC = 0;

  // Enumerates exactly the opcodes matching (op[5]=0 & (op[3]=0 | op[1:0]=00)) plus shifts.
  function automatic logic is_legal(logic [OpW-1:0] op);
    case (op)
      OpAdd, OpAnd, OpOr, OpXor, OpSub, OpAndn, OpOrn, OpXnor, OpAddx, OpSubx,
      OpAddcc, OpAndcc, OpOrcc, OpXorcc, OpSubcc, OpAndncc, OpOrncc, OpXnorcc,
      OpAddxcc, OpSubxcc, OpSll, OpSrl, OpSra: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_arith(logic [OpW-1:0] op);
    return !op[5] && (op[1:0] == 2'b00);
  endfunction

  function automatic logic sets_cc(logic [OpW-1:0] op);
    return !op[5] && op[4];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr+1 (mod NUM_REQ)
// wins; grant is one-hot or all zero.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + 32'd1 + i) % NUM_REQ;
      if (!found && req[idx[IdxW-1:0]]) begin
        grant[idx[IdxW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer_arb.sv
// Arbitrates NUM_REQ requesters onto one SPARC integer ALU, sequences its edge-triggered
// enable, and owns the architectural icc flags.
module alu_sequencer_arb
  import alu_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = OpW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_result,
  output logic                      resp_err,
  output logic [3:0]                icc_q,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  output logic                      alu_carry,
  output logic                      alu_enable,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_n,
  input  logic                      alu_z,
  input  logic                      alu_v,
  input  logic                      alu_c
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [OP_W-1:0]   op_q;
  logic [IdxW-1:0]   owner_q, last_q;
  logic              err_q;
  logic [3:0]        icc_d;

  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]    gnt_idx;
  logic [DATA_W-1:0]  gnt_a, gnt_b;
  logic [OP_W-1:0]    gnt_op;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IdxW   (IdxW)
  ) u_arb (
    .req  (req_valid),
    .ptr  (last_q),
    .grant(grant)
  );

  always_comb begin
    gnt_idx = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    gnt_op  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx = IdxW'(i);
        gnt_a   = req_a[i*DATA_W +: DATA_W];
        gnt_b   = req_b[i*DATA_W +: DATA_W];
        gnt_op  = req_op[i*OP_W +: OP_W];
      end
    end
  end

  assign accept    = (state_q == StIdle) && (|grant);
  assign req_ready = (state_q == StIdle) ? grant : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = is_legal(gnt_op) ? StSetup : StResp;
      end
      StSetup:   state_d = StStrobe;
      StStrobe:  state_d = StCapture;
      StCapture: state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Flags only move at the end of CAPTURE for S-ops; logical ops clear V and C.
  always_comb begin
    icc_d = icc_q;
    if (state_q == StCapture && sets_cc(op_q)) begin
      icc_d[IccN] = alu_n;
      icc_d[IccZ] = alu_z;
      icc_d[IccV] = is_arith(op_q) ? alu_v : 1'b0;
      icc_d[IccC] = is_arith(op_q) ? alu_c : 1'b0;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == StResp) resp_valid[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      owner_q    <= '0;
      last_q     <= IdxW'(NUM_REQ - 1);
      result_q   <= '0;
      err_q      <= 1'b0;
      icc_q      <= 4'b0000;
      alu_enable <= 1'b0;
    end else begin
      state_q    <= state_d;
      icc_q      <= icc_d;
      // Registered so the ALU sees a glitch-free rising edge exactly while in STROBE.
      alu_enable <= (state_d == StStrobe);
      if (accept) begin
        a_q     <= gnt_a;
        b_q     <= gnt_b;
        op_q    <= gnt_op;
        owner_q <= gnt_idx;
        last_q  <= gnt_idx;
        if (!is_legal(gnt_op)) begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
      end
      if (state_q == StCapture) begin
        result_q <= alu_result;
        err_q    <= 1'b0;
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign alu_carry   = icc_q[IccC];
  assign resp_result = result_q;
  assign resp_err    = err_q;

endmodule

// File: doc/alu_sequencer_arb.md
Name: alu_sequencer_arb

Overview:
Shares the single 32-bit SPARC integer ALU between NUM_REQ requesters (e.g. integer execute and address generation) with round-robin arbitration. Drives the ALU's edge-triggered enable with a clean setup/strobe/capture sequence. Owns the architectural icc register (N,Z,V,C) and applies SPARC flag rules per opcode. Rejects opcodes the ALU does not implement.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
DATA_W, 32, operand/result width
OP_W, 6, ALU opcode width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  per-requester accept (combinational)
req_a  in  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand B, same packing
req_op  in  NUM_REQ*OP_W  opcode, same packing
resp_valid  out  NUM_REQ  one-hot, one-cycle response to the owning requester
resp_result  out  DATA_W  captured result
resp_err  out  1  illegal opcode
icc_q  out  4  {N,Z,V,C} architectural flags
alu_a, alu_b  out  DATA_W  to ALU A_in/B_in
alu_op  out  OP_W  to ALU opcode
alu_carry  out  1  to ALU carry (= icc_q C)
alu_enable  out  1  to ALU ALUE (registered; ALU acts on its rising edge)
alu_result  in  DATA_W  from ALU
alu_n, alu_z, alu_v, alu_c  in  1  ALU flags

Behaviour:
- Reset: state IDLE; all outputs 0; icc_q=4'b0000; RR pointer so requester 0 has priority. Reset mid-operation aborts: no resp_valid, alu_enable low next cycle, icc unchanged by the aborted op (it clears to 0).
- FSM: IDLE -> SETUP -> STROBE -> CAPTURE -> RESP -> IDLE; illegal op: IDLE -> RESP.
- IDLE: grant = first valid requester at/after (last_grant+1) mod NUM_REQ; req_ready[grant]=1 only in IDLE; no other ready bit is high. Accept latches A, B, op, and owner index; last_grant updates.
- Legal op: (op[5]=0 and (op[3]=0 or op[1:0]=00)) or op in {100101,100110,100111}.
- SETUP (1 cycle): alu_a/b/op/carry driven from latched regs, alu_enable=0.
- STROBE (1 cycle): alu_enable=1; operands held stable.
- CAPTURE (1 cycle): alu_enable=0; at cycle end latch alu_result into resp_result and update icc if op[5]=0 and op[4]=1:
  - arithmetic (op[3:0] in 0000,1000,0100,1100): icc={alu_n,alu_z,alu_v,alu_c}
  - logical: icc={alu_n,alu_z,0,0}
  - op[4]=0 or shift: icc unchanged.
- RESP (1 cycle): resp_valid[owner]=1, resp_err per legality; illegal gives resp_result=0 and no alu_enable pulse, icc unchanged.
- Latency accept->resp_valid: 4 cycles legal, 1 illegal; next accept is possible the cycle after RESP (throughput 1 op / 5 cycles).
- alu_carry always reflects icc_q C at SETUP, so addx/subx chains see the previous S-op carry.
- req_valid deasserted after accept has no effect; requests not accepted must be held by the requester.
- resp_result/resp_err hold their value until the next capture.

Decomposition:
- Package alu_seq_pkg: state encoding, opcode constants (ADD, ADDCC, ADDX, ADDXCC, SUB, SUBCC, SUBX, SUBXCC, AND..XNORCC, SLL, SRL, SRA), icc bit indices, and the is_legal/is_arith/sets_cc functions.
- One sub-module: rr_arbiter (NUM_REQ request vector plus pointer in, one-hot grant out), combinational.

Test Plan:
- Reset then req0 ADDCC (op 010000) A=32'hFFFF_FFFF B=1 -> alu_enable high exactly 1 cycle at cycle 2, resp_valid=2'b01 at cycle 4, result 0, icc=4'b0101.
- ADDX (op 001000) A=5 B=3 right after the above -> alu_carry=1, result 9, icc unchanged 4'b0101.
- SUBCC A=32'h8000_0000 B=1 -> result 32'h7FFF_FFFF, icc={0,0,1,x per ALU C}; ANDCC A=32'hF0 B=32'h0F -> result 0, icc=4'b0100 (V,C cleared).
- Both requesters valid continuously with ORs -> grants alternate 0,1,0,1; each gets resp_valid one-hot to itself; ready is never high for both.
- Illegal op 6'b001001 from req1 -> no alu_enable pulse, resp_valid=2'b10 one cycle after accept, resp_err=1, result 0, icc unchanged.
- reset asserted during STROBE -> next cycle alu_enable=0, state IDLE, no resp_valid, icc=0; a following SLL A=1 B=4 -> result 16.
